// File: rtl/wbq_pkg.sv
// Shared types and constants for the register-file write-back queue:
// producer grant encoding and the queued write-back entry layout.
package wbq_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MD  = 1'b1
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_rr_arbiter.sv
// Two-producer round-robin arbiter (ALU vs mult/div) for the write-back queue.
// Grants at most one push per cycle; the last accepted producer loses the
// next contested cycle. Nothing is granted while the queue has no space.
module wbq_rr_arbiter
    import wbq_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_alu_valid,
    input  logic   i_md_valid,
    input  logic   i_space,
    output logic   o_alu_ready,
    output logic   o_md_ready,
    output grant_e o_grant,
    output logic   o_push
);

    grant_e r_last_grant;

    // Pick the producer for this cycle and derive the handshake readys.
    always_comb begin
        o_grant = GRANT_ALU;
        if (i_alu_valid && i_md_valid) begin
            o_grant = (r_last_grant == GRANT_MD) ? GRANT_ALU : GRANT_MD;
        end else if (i_md_valid) begin
            o_grant = GRANT_MD;
        end
        o_alu_ready = i_space && i_alu_valid && (o_grant == GRANT_ALU);
        o_md_ready  = i_space && i_md_valid  && (o_grant == GRANT_MD);
        o_push      = o_alu_ready || o_md_ready;
    end

    // Remember the winner of each accepted push; reset favours the ALU first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= GRANT_MD;
        end else if (o_push) begin
            r_last_grant <= o_grant;
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// In-order write-back queue in front of the register-file write port.
// Accepts requests from the ALU and mult/div producers, drains one per cycle
// unless wb_stall borrows the port. Writes to r0 are accepted and dropped.
// Optional forwarding lookup over queued entries: REGFILE_WRITE_QUEUE_FWD_EN.
module regfile_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     md_valid,
    input  logic [ADDR_W-1:0]        md_rd,
    input  logic [DATA_W-1:0]        md_data,
    output logic                     md_ready,
    input  logic                     wb_stall,
    output logic                     ctrl_writeEnable,
    output logic [ADDR_W-1:0]        ctrl_writeReg,
    output logic [DATA_W-1:0]        data_writeReg,
    output logic [$clog2(DEPTH):0]   count
`ifdef REGFILE_WRITE_QUEUE_FWD_EN
    ,
    input  logic [ADDR_W-1:0]        fwd_rs,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data
`endif
);

    import wbq_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [ADDR_W-1:0] r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_empty;
    logic              w_pop;
    logic              w_space;
    logic              w_push;
    logic              w_enq;
    grant_e            w_grant;
    logic [ADDR_W-1:0] w_in_rd;
    logic [DATA_W-1:0] w_in_data;

    // Drain and space decisions; a full queue that drains still takes one push.
    always_comb begin
        w_empty = (r_count == '0);
        w_pop   = !w_empty && !wb_stall;
        w_space = (r_count < DEPTH_C) || w_pop;
    end

    wbq_rr_arbiter u_arb (
        .i_clk       (clock),
        .i_rst       (clear),
        .i_alu_valid (alu_valid),
        .i_md_valid  (md_valid),
        .i_space     (w_space),
        .o_alu_ready (alu_ready),
        .o_md_ready  (md_ready),
        .o_grant     (w_grant),
        .o_push      (w_push)
    );

    // Select the granted request; r0 writes are acknowledged but never stored.
    always_comb begin
        w_in_rd   = (w_grant == GRANT_MD) ? md_rd   : alu_rd;
        w_in_data = (w_grant == GRANT_MD) ? md_data : alu_data;
        w_enq     = w_push && (w_in_rd != '0);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage, written at the tail on every stored push.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else if (w_enq) begin
            r_rd[r_wptr]   <= w_in_rd;
            r_data[r_wptr] <= w_in_data;
        end
    end

    // Register-file port driven from the registered head; zero while empty.
    always_comb begin
        ctrl_writeEnable = w_pop;
        ctrl_writeReg    = w_empty ? '0 : r_rd[r_rptr];
        data_writeReg    = w_empty ? '0 : r_data[r_rptr];
        count            = r_count;
    end

`ifdef REGFILE_WRITE_QUEUE_FWD_EN
    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        v_idx    = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            v_idx = r_rptr + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (fwd_rs != '0) && (r_rd[v_idx] == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data[v_idx];
            end
        end
    end
`endif

endmodule
